// File: rtl/request_if.sv
// Cache-side request/hit bundle between the request unit (master) and the
// instruction/data cache interface (slave).
interface request_if;
    logic        ihit;
    logic        dhit;
    logic        imemREN;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;

    modport master (
        input  ihit, dhit,
        output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore
    );

    modport slave (
        output ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore
    );
endinterface

// File: rtl/request_unit.sv
// Memory request sequencer for the single-cycle MIPS datapath: fetch/data
// request handshake, retire pulse, LL/SC link register and sticky halt.
module request_unit (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              cu_dREN,
    input  logic              cu_dWEN,
    input  logic              cu_datomic,
    input  logic              cu_halt,
    input  logic [31:0]       alu_addr,
    input  logic [31:0]       store_data,
    input  logic              snoop_valid,
    input  logic [31:0]       snoop_addr,
    request_if.master         mem,
    output logic              pc_en,
    output logic              sc_success,
    output logic              halt
);
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FETCH, DATA, SCFAIL, HALTED} state_t;

    state_t        state, next_state;
    logic          dren_q, dwen_q, atom_q, sc_ok_q;
    word_t         addr_q, store_q;
    logic          link_valid;
    logic [31:2]   link_addr;

    logic          load_fields;
    logic          sc_ok_d;
    logic          is_sc, link_match;
    logic          data_done, sc_retire, ll_done, snoop_hit, store_hit;

    assign is_sc      = cu_dWEN & cu_datomic;
    assign link_match = link_valid & (link_addr == alu_addr[31:2]);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        next_state  = state;
        pc_en       = 1'b0;
        load_fields = 1'b0;
        sc_ok_d     = 1'b0;
        unique case (state)
            FETCH: begin
                if (mem.ihit) begin
                    if (cu_halt) begin
                        next_state = HALTED;
                    end else if (cu_dREN | cu_dWEN) begin
                        load_fields = 1'b1;
                        if (is_sc && !link_match) begin
                            next_state = SCFAIL;
                        end else begin
                            sc_ok_d    = is_sc;
                            next_state = DATA;
                        end
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            DATA: begin
                if (mem.dhit) begin
                    pc_en      = 1'b1;
                    next_state = FETCH;
                end
            end
            SCFAIL: begin
                pc_en      = 1'b1;
                next_state = FETCH;
            end
            HALTED: next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            atom_q  <= 1'b0;
            sc_ok_q <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else if (load_fields) begin
            dren_q  <= cu_dREN;
            dwen_q  <= cu_dWEN;
            atom_q  <= cu_datomic;
            sc_ok_q <= sc_ok_d;
            addr_q  <= alu_addr;
            store_q <= store_data;
        end
    end

    assign data_done = (state == DATA) & mem.dhit;
    assign sc_retire = (data_done & dwen_q & atom_q) | (state == SCFAIL);
    assign ll_done   = data_done & dren_q & atom_q;
    assign snoop_hit = snoop_valid & (snoop_addr[31:2] == link_addr);
    assign store_hit = data_done & dwen_q & ~atom_q & (addr_q[31:2] == link_addr);

    // Priority: SC retire, then LL set (beats a same-cycle snoop), then clears.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (sc_retire) begin
            link_valid <= 1'b0;
        end else if (ll_done) begin
            link_valid <= 1'b1;
            link_addr  <= addr_q[31:2];
        end else if (snoop_hit | store_hit) begin
            link_valid <= 1'b0;
        end
    end

    assign mem.imemREN   = (state == FETCH);
    assign mem.dmemREN   = (state == DATA) & dren_q;
    assign mem.dmemWEN   = (state == DATA) & dwen_q;
    assign mem.dmemaddr  = addr_q;
    assign mem.dmemstore = store_q;
    assign sc_success    = sc_ok_q;
    assign halt          = (state == HALTED);
endmodule

// File: tb/tb_request_unit.sv
// Directed bench for request_unit: fetch/retire, load latency, LL/SC with
// snoops and local stores, sticky halt and asynchronous reset mid-access.
module tb_request_unit;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        cu_dREN, cu_dWEN, cu_datomic, cu_halt;
    logic [31:0] alu_addr, store_data, snoop_addr;
    logic        snoop_valid;
    logic        pc_en, sc_success, halt;
    int          checks = 0;
    int          errors = 0;

    request_if mem ();

    request_unit dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .cu_dREN     (cu_dREN),
        .cu_dWEN     (cu_dWEN),
        .cu_datomic  (cu_datomic),
        .cu_halt     (cu_halt),
        .alu_addr    (alu_addr),
        .store_data  (store_data),
        .snoop_valid (snoop_valid),
        .snoop_addr  (snoop_addr),
        .mem         (mem.master),
        .pc_en       (pc_en),
        .sc_success  (sc_success),
        .halt        (halt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        cu_dREN = 0; cu_dWEN = 0; cu_datomic = 0; cu_halt = 0;
        mem.ihit = 0; mem.dhit = 0; snoop_valid = 0;
        snoop_addr = 32'h0; alu_addr = 32'hFFFF_FFF0; store_data = 32'h0;
    endtask

    // Advance to 1 time unit after the next rising edge, then let inputs settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Issue an instruction in FETCH with ihit; the following tick enters DATA.
    task automatic issue(input logic rd, input logic wr, input logic at, input logic [31:0] a, input logic [31:0] d);
        idle();
        mem.ihit = 1; cu_dREN = rd; cu_dWEN = wr; cu_datomic = at;
        alu_addr = a; store_data = d;
    endtask

    initial begin
        idle();
        nRST = 0;
        #3;
        check("rst_imemREN", {31'b0, mem.imemREN}, 32'd1);
        check("rst_dmemREN", {31'b0, mem.dmemREN}, 32'd0);
        check("rst_dmemWEN", {31'b0, mem.dmemWEN}, 32'd0);
        check("rst_pc_en",   {31'b0, pc_en}, 32'd0);
        check("rst_halt",    {31'b0, halt}, 32'd0);
        check("rst_sc",      {31'b0, sc_success}, 32'd0);
        check("rst_addr",    mem.dmemaddr, 32'h0);
        check("rst_store",   mem.dmemstore, 32'h0);
        check("rst_link",    {31'b0, dut.link_valid}, 32'd0);
        @(negedge CLK);
        nRST = 1;
        tick();

        // ADD: retires in the ihit cycle
        idle(); mem.ihit = 1; settle();
        check("add_pc_en",   {31'b0, pc_en}, 32'd1);
        check("add_imemREN", {31'b0, mem.imemREN}, 32'd1);
        check("add_dreq",    {30'b0, mem.dmemREN, mem.dmemWEN}, 32'd0);
        tick(); idle(); settle();
        check("add_after_pc", {31'b0, pc_en}, 32'd0);
        check("add_after_imem", {31'b0, mem.imemREN}, 32'd1);

        // LW 0x100, dhit on the third data cycle
        issue(1, 0, 0, 32'h100, 32'h0); settle();
        check("lw_issue_pc", {31'b0, pc_en}, 32'd0);
        tick(); idle(); settle();
        for (int i = 0; i < 2; i++) begin
            check("lw_wait_ren",  {31'b0, mem.dmemREN}, 32'd1);
            check("lw_wait_addr", mem.dmemaddr, 32'h100);
            check("lw_wait_pc",   {30'b0, pc_en, mem.imemREN}, 32'd0);
            tick(); settle();
        end
        mem.dhit = 1; settle();
        check("lw_hit_ren", {31'b0, mem.dmemREN}, 32'd1);
        check("lw_hit_pc",  {31'b0, pc_en}, 32'd1);
        tick(); idle(); settle();
        check("lw_done", {29'b0, mem.imemREN, mem.dmemREN, pc_en}, 32'b100);

        // LL 0x200 then SC 0x200; a snoop during the SC wait does not abort it
        issue(1, 0, 1, 32'h200, 32'h0); tick();
        idle(); mem.dhit = 1; settle();
        check("ll_pc", {31'b0, pc_en}, 32'd1);
        tick(); idle(); settle();
        check("ll_link", {31'b0, dut.link_valid}, 32'd1);
        issue(0, 1, 1, 32'h200, 32'hDEAD); settle();
        check("sc_issue_pc", {31'b0, pc_en}, 32'd0);
        tick(); idle(); snoop_valid = 1; snoop_addr = 32'h200; settle();
        check("sc_wen",   {31'b0, mem.dmemWEN}, 32'd1);
        check("sc_store", mem.dmemstore, 32'hDEAD);
        check("sc_addr",  mem.dmemaddr, 32'h200);
        tick(); idle(); settle();
        check("sc_snoop_link", {31'b0, dut.link_valid}, 32'd0);
        check("sc_still_wen",  {31'b0, mem.dmemWEN}, 32'd1);
        mem.dhit = 1; settle();
        check("sc_ret_pc", {31'b0, pc_en}, 32'd1);
        check("sc_ret_ok", {31'b0, sc_success}, 32'd1);
        tick(); idle(); settle();
        check("sc_after_link", {31'b0, dut.link_valid}, 32'd0);
        check("sc_after_imem", {31'b0, mem.imemREN}, 32'd1);

        // LL with a same-cycle matching snoop: LL wins
        issue(1, 0, 1, 32'h200, 32'h0); tick();
        idle(); mem.dhit = 1; snoop_valid = 1; snoop_addr = 32'h200; tick();
        idle(); settle();
        check("ll_vs_snoop", {31'b0, dut.link_valid}, 32'd1);
        snoop_valid = 1; snoop_addr = 32'h204; tick();
        idle(); settle();
        check("snoop_204_keep", {31'b0, dut.link_valid}, 32'd1);
        snoop_valid = 1; snoop_addr = 32'h203; tick();
        idle(); settle();
        check("snoop_203_clear", {31'b0, dut.link_valid}, 32'd0);
        issue(0, 1, 1, 32'h200, 32'hBEEF); settle();
        check("scf_issue_pc", {31'b0, pc_en}, 32'd0);
        tick(); idle(); settle();
        check("scf_noreq", {29'b0, mem.imemREN, mem.dmemREN, mem.dmemWEN}, 32'd0);
        check("scf_pc",    {31'b0, pc_en}, 32'd1);
        check("scf_ok",    {31'b0, sc_success}, 32'd0);
        tick(); settle();
        check("scf_back", {30'b0, mem.imemREN, pc_en}, 32'b10);

        // Local SW to the linked word clears the link
        issue(1, 0, 1, 32'h300, 32'h0); tick();
        idle(); mem.dhit = 1; tick();
        issue(0, 1, 0, 32'h302, 32'h55); tick();
        idle(); mem.dhit = 1; tick();
        idle(); settle();
        check("sw_clear_link", {31'b0, dut.link_valid}, 32'd0);

        // HALT: sticky, ignores further ihit, cleared only by reset
        idle(); mem.ihit = 1; cu_halt = 1; settle();
        check("halt_pc", {30'b0, pc_en, halt}, 32'd0);
        tick(); idle(); settle();
        check("halt_set", {29'b0, halt, mem.imemREN, pc_en}, 32'b100);
        mem.ihit = 1; settle();
        check("halt_ign_pc", {31'b0, pc_en}, 32'd0);
        tick(); settle();
        check("halt_stay", {31'b0, halt}, 32'd1);
        nRST = 0; #1;
        check("halt_rst", {30'b0, halt, mem.imemREN}, 32'b01);
        @(negedge CLK); nRST = 1; tick();

        // Reset while a SW waits in DATA drops the request and the link
        issue(1, 0, 1, 32'h400, 32'h0); tick();
        idle(); mem.dhit = 1; tick();
        issue(0, 1, 0, 32'h400, 32'h1234); tick();
        idle(); settle();
        check("rsw_wen", {31'b0, mem.dmemWEN}, 32'd1);
        check("rsw_link_pre", {31'b0, dut.link_valid}, 32'd1);
        nRST = 0; #1;
        check("rsw_wen_drop", {31'b0, mem.dmemWEN}, 32'd0);
        check("rsw_link_lost", {31'b0, dut.link_valid}, 32'd0);
        @(negedge CLK); nRST = 1; tick(); settle();
        check("rsw_fetch", {30'b0, mem.imemREN, mem.dmemWEN}, 32'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/request_unit.md
# request_unit

Sequences memory requests for the single-cycle MIPS datapath: takes the control unit's decoded `iREN`/`dREN`/`dWEN`/`datomic`/`halt` for the current instruction, drives the instruction and data request lines to the cache side, and waits on `ihit`/`dhit`. It emits a one-cycle `pc_en` when the instruction retires. It holds the LL/SC link register, including snoop invalidation, and makes halt sticky. It sits between the control unit and the datapath/cache interface.

## Interface
- No parameters; word width fixed at 32 (`word_t`).
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous reset, active-low.
- `cu_dREN` in 1: current instruction reads data memory (LW/LL).
- `cu_dWEN` in 1: current instruction writes data memory (SW/SC).
- `cu_datomic` in 1: with `cu_dREN` = LL, with `cu_dWEN` = SC.
- `cu_halt` in 1: current instruction is HALT.
- `alu_addr` in 32: data address from the ALU.
- `store_data` in 32: rt value for stores.
- `ihit` in 1: instruction fetch complete this cycle.
- `dhit` in 1: data access complete this cycle.
- `snoop_valid` in 1: a remote write is observed this cycle.
- `snoop_addr` in 32: address of that remote write.
- `imemREN` out 1: instruction fetch request.
- `dmemREN` out 1: data read request.
- `dmemWEN` out 1: data write request.
- `dmemaddr` out 32: latched data address.
- `dmemstore` out 32: latched store data.
- `pc_en` out 1: one-cycle pulse; the instruction retires and PC advances.
- `sc_success` out 1: SC outcome. Valid in the retire cycle of an SC.
- `halt` out 1: sticky halt.

## Operation
- States: FETCH, DATA, SCFAIL, HALTED. Reset state is FETCH.
- Latched fields: `dren_q`, `dwen_q`, `atom_q`, `addr_q`, `store_q`, `sc_ok_q`. All load on the FETCH→DATA/SCFAIL transition only.
- Link register: `link_valid`, `link_addr[31:2]`.
- Outputs:
  - `imemREN` = (state==FETCH).
  - `dmemREN` = (state==DATA)&`dren_q`.
  - `dmemWEN` = (state==DATA)&`dwen_q`.
  - `dmemaddr` = `addr_q`; `dmemstore` = `store_q`.
- FETCH, `ihit`=0: stay.
- FETCH, `ihit`=1 & `cu_halt`: go to HALTED. No `pc_en`.
- FETCH, `ihit`=1 & neither `cu_dREN` nor `cu_dWEN`: assert `pc_en` this cycle; stay in FETCH.
- FETCH, `ihit`=1 & (`cu_dREN`|`cu_dWEN`):
  - Latch fields.
  - SC (`cu_dWEN`&`cu_datomic`) with `link_valid`=1 and `link_addr`==`alu_addr[31:2]`: `sc_ok_q`←1, go to DATA.
  - SC with any other link condition: `sc_ok_q`←0, go to SCFAIL.
  - All other loads/stores: go to DATA.
- DATA, `dhit`=0: hold requests; stay.
- DATA, `dhit`=1: assert `pc_en`; go to FETCH.
- SCFAIL: no memory request. Assert `pc_en` for one cycle; go to FETCH.
- HALTED: terminal until `nRST`. `halt`=1, all requests 0, `pc_en`=0.
- `sc_success` = `sc_ok_q`. It is meaningful only while `pc_en`=1 for an SC.
- Link updates, in priority order, applied at the clock edge:
  1. Reset: clear `link_valid`.
  2. Any SC retiring (DATA+`dhit`, or SCFAIL): clear `link_valid`.
  3. LL completing (DATA+`dhit`+`dren_q`+`atom_q`): `link_valid`←1, `link_addr`←`addr_q[31:2]`.
  4. `snoop_valid` with `snoop_addr[31:2]`==`link_addr`: clear.
  5. Local non-atomic store completing to `link_addr`: clear.
- If an LL completion and a matching snoop occur in the same cycle, the LL wins: link set, snoop ignored.
- The SC serialization point is FETCH→DATA. A snoop arriving while an SC waits in DATA clears the link but does not abort the SC; it still retires with `sc_success`=1.

## Timing
- Reset values:
  - state FETCH, so `imemREN`=1.
  - `dmemREN`, `dmemWEN`, `pc_en`, `halt`, `sc_success` all 0.
  - `dmemaddr`, `dmemstore` = 0. `link_valid`=0.
- `ihit`/`dhit` are sampled the same cycle they are asserted. `pc_en` is combinational from state plus hit.
- Latency from `ihit`:
  - Non-memory instruction: retires in that cycle.
  - Load/store: first data request the following cycle; retires in the `dhit` cycle.
  - SCFAIL: retires exactly 1 cycle after `ihit`.
- `halt` rises the cycle after the HALT `ihit`.
- Requests hold stable until their hit; there is no retraction in DATA.
- `nRST` asserted mid-DATA drops `dmemREN`/`dmemWEN` immediately (asynchronously) and loses the link.
- Address compares use bits [31:2] only.

## Test plan
- ADD-type instruction: `ihit` in cycle 1, `cu_dREN`=`cu_dWEN`=0 -> `pc_en`=1 in cycle 1; `imemREN` stays 1; `dmemREN`/`dmemWEN` stay 0.
- LW to 0x100 with `dhit` delayed 3 cycles -> `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles; `pc_en` pulses once in the `dhit` cycle.
- LL to 0x200, then SC to 0x200 with store 0xDEAD -> `dmemWEN`=1, `dmemstore`=0xDEAD; `sc_success`=1 at retire; `link_valid`=0 after.
- LL to 0x200, then `snoop_valid` with 0x204, then `snoop_valid` with 0x200, then SC to 0x200 -> 0x204 leaves the link set; 0x200 clears it; SC goes to SCFAIL with no `dmemWEN`; `sc_success`=0; `pc_en` 1 cycle after `ihit`.
- HALT with `ihit` -> no `pc_en`; `halt`=1 next cycle and stays 1; further `ihit` ignored; `nRST` low returns to FETCH with `halt`=0.
- `nRST` pulsed while a SW waits in DATA -> `dmemWEN` drops immediately; after release, state is FETCH and `imemREN`=1.
